x_feed_ctrl: RTL
================

Name: x_feed_ctrl

Overview:
Control stage directly upstream of the bank of ROWS X_REG row buffers that feed the systolic array.
- Load phase: per job, reads LEN activation words from the activation BRAM and writes them into all X_REG rows in parallel, using a shared index.
- Drain phase: issues the skewed per-row shift enables (row r starts r cycles after row 0).
- Emits a per-row valid aligned with each X_REG registered output, so the array knows when its row inputs are live.

Parameters:
ROWS, 8, number of X_REG rows / array rows
DEPTH, 32, entries per X_REG (index width 5)
DW, 8, element width
AW, 10, BRAM word-address width
LW, 6, LEN width, = $clog2(DEPTH+1)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous, active-high reset
START  in  1  job request, sampled only in IDLE
BASE_ADDR  in  AW  first BRAM word of job
LEN  in  LW  elements per row, 0..DEPTH
BUSY  out  1  job in progress
DONE  out  1  one-cycle job-complete pulse
MEM_EN  out  1  BRAM read enable
MEM_ADDR  out  AW  BRAM read address
MEM_DATA  in  ROWS*DW  read data, 1-cycle latency; lane r = element for row r
XR_EN  out  ROWS  per-row X_REG EN
XR_WRITE  out  ROWS  per-row X_REG WRITE
XR_IDX  out  5  shared X_REG write index
XR_DIN  out  ROWS*DW  per-row X_REG DIN
ROW_VALID  out  ROWS  row r X_REG DOUT is valid this cycle

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, LOAD, DRAIN, FIN.
- IDLE:
  - On START=1, latch BASE_ADDR and min(LEN,DEPTH).
  - If latched LEN=0: go to FIN; no memory access, no X_REG activity.
  - Otherwise go to LOAD.
- Timing below uses cycle 0 = the START cycle.
- LOAD:
  - Cycles 1..LEN: MEM_EN=1, MEM_ADDR=BASE_ADDR+k for k=0..LEN-1.
  - Address arithmetic is modulo 2^AW; wrap is allowed.
  - A registered (valid, idx) pipe tracks outstanding reads.
  - Cycles 2..LEN+1: XR_EN=all 1, XR_WRITE=all 1, XR_IDX=k, XR_DIN=MEM_DATA (combinational pass-through).
  - Go to DRAIN after the last read is issued. The final write overlaps the first DRAIN cycle at cycle LEN+1.
- DRAIN:
  - Counter c runs 0..LEN+ROWS-2 during cycles LEN+2+c.
  - Row r: XR_EN[r]=1 and XR_WRITE[r]=0 iff r <= c < r+LEN. XR_WRITE=0 outside LOAD.
  - ROW_VALID[r] is XR_EN[r]&~XR_WRITE[r] delayed one cycle, matching the X_REG output register.
  - Go to FIN after c = LEN+ROWS-2.
- FIN:
  - Single cycle at 2*LEN+ROWS+1. DONE=1, coinciding with the last ROW_VALID[ROWS-1].
  - Next state IDLE.
  - For LEN=0, FIN occurs at cycle 1.
- BUSY: 1 in LOAD, DRAIN and FIN; 0 in IDLE. START while BUSY is ignored (no queueing).
- Entries beyond LEN in X_REG are stale but never shifted out within LEN drain cycles. No clearing is required.
- RST mid-job:
  - Next cycle: IDLE with all outputs 0.
  - In-flight read data is discarded.
  - X_REG contents are left as-is, since X_REG has no reset.
- LEN > DEPTH is clamped to DEPTH.
- MEM_DATA is ignored outside the write window.

Decomposition:
- Package x_feed_pkg holds:
  - state enum: IDLE, LOAD, DRAIN, FIN
  - defaults for ROWS, DEPTH, DW, AW
  - LW computation
  - helper function for clamped LEN
- One sub-module, x_skew_gen:
  - Inputs: c, LEN, active.
  - Outputs: ROWS drain enables, plus the 1-cycle-delayed ROW_VALID register.
- FSM, address counter and read pipe stay in x_feed_ctrl.

Test Plan:
1. Basic job (ROWS=8, LEN=4, BASE=0x010).
   - Required: MEM_ADDR 0x010..0x013 in cycles 1-4; XR_WRITE=0xFF with IDX 0..3 in cycles 2-5.
   - Required: row0 drain cycles 6-9, row7 drain 13-16; ROW_VALID[7] cycles 14-17; DONE at cycle 17; BUSY cycles 1-17.
2. LEN=0.
   - Required: DONE at cycle 1, BUSY only in cycle 1, MEM_EN and XR_EN never asserted.
3. LEN=40 (above DEPTH).
   - Required: clamped to 32; 32 reads; IDX 0..31; DONE at cycle 2*32+8+1=73.
4. BASE=0x3FE, LEN=4.
   - Required: MEM_ADDR sequence 0x3FE, 0x3FF, 0x000, 0x001.
5. START pulsed at cycle 5 during a LEN=4 job.
   - Required: ignored; a single DONE at cycle 17; a START after return to IDLE begins a new job.
6. RST asserted at cycle 7 of a LEN=4 job.
   - Required: from cycle 8 all outputs 0, BUSY=0, no DONE.
   - Required: a following START with LEN=2 completes with DONE at cycle 2*2+8+1=13 relative to that START.

Source files
------------

// File: rtl/x_feed_pkg.sv
// Shared types, default sizes and sizing helpers for the X_REG feed controller.
package x_feed_pkg;

  localparam int X_ROWS  = 8;
  localparam int X_DEPTH = 32;
  localparam int X_DW    = 8;
  localparam int X_AW    = 10;
  localparam int X_LW    = $clog2(X_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } x_state_e;

  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Drain counter must reach LEN+ROWS-2 for the largest legal LEN.
  function automatic int cnt_w(input int rows, input int depth);
    return $clog2(depth + rows);
  endfunction

  function automatic int clamp_len(input int len, input int depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/x_skew_gen.sv
// Skewed per-row drain enables and the matching one-cycle-late row valid flags.
module x_skew_gen
  import x_feed_pkg::*;
#(
  parameter int ROWS = X_ROWS,
  parameter int LW   = X_LW,
  parameter int CW   = cnt_w(X_ROWS, X_DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CW-1:0]   c,
  input  logic [LW-1:0]   len,
  input  logic            active,
  output logic [ROWS-1:0] drain_en,
  output logic [ROWS-1:0] row_valid
);

  localparam int XW = CW + 1;

  logic [XW-1:0] c_x;
  logic [XW-1:0] len_x;

  assign c_x   = XW'(c);
  assign len_x = XW'(len);

  // Row r shifts while r <= c < r+LEN.
  always_comb begin
    drain_en = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (active && (c_x >= XW'(r)) && (c_x < (XW'(r) + len_x))) begin
        drain_en[r] = 1'b1;
      end
    end
  end

  // Mirrors the X_REG output register: data shifted out this cycle is on DOUT next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_valid <= '0;
    end else begin
      row_valid <= drain_en;
    end
  end

endmodule

// File: rtl/x_feed_ctrl.sv
// Loads one job of activation words into every X_REG row, then drains the rows skewed by row index.
module x_feed_ctrl
  import x_feed_pkg::*;
#(
  parameter int ROWS  = X_ROWS,
  parameter int DEPTH = X_DEPTH,
  parameter int DW    = X_DW,
  parameter int AW    = X_AW,
  parameter int LW    = len_w(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [AW-1:0]             BASE_ADDR,
  input  logic [LW-1:0]             LEN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      MEM_EN,
  output logic [AW-1:0]             MEM_ADDR,
  input  logic [ROWS*DW-1:0]        MEM_DATA,
  output logic [ROWS-1:0]           XR_EN,
  output logic [ROWS-1:0]           XR_WRITE,
  output logic [$clog2(DEPTH)-1:0]  XR_IDX,
  output logic [ROWS*DW-1:0]        XR_DIN,
  output logic [ROWS-1:0]           ROW_VALID
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = cnt_w(ROWS, DEPTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_FIN   = FIN;

  logic [1:0]      state_q;
  x_state_e        dbg_state;
  logic [AW-1:0]   addr_q;
  logic [IW-1:0]   k_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   start_len;
  logic            rd_vld_q;
  logic [IW-1:0]   rd_idx_q;
  logic            drain_go_q;
  logic [CW-1:0]   c_q;
  logic [CW-1:0]   c_last;
  logic            drain_active;
  logic [ROWS-1:0] drain_en;

  assign dbg_state = x_state_e'(state_q);
  assign start_len = LW'(clamp_len(int'(LEN), DEPTH));
  assign c_last    = CW'(len_q) + CW'(ROWS - 2);

  // Handshake: START is a request taken only while BUSY=0 (IDLE); a START seen while
  // BUSY=1 is dropped, never queued. Each MEM_EN cycle is a read whose data is consumed
  // exactly one cycle later via the rd_vld_q/rd_idx_q pipe, with no backpressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      k_q        <= '0;
      len_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      drain_go_q <= 1'b0;
      c_q        <= '0;
    end else begin
      rd_vld_q <= (state_q == S_LOAD);
      rd_idx_q <= k_q;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            len_q      <= start_len;
            addr_q     <= BASE_ADDR;
            k_q        <= '0;
            c_q        <= '0;
            drain_go_q <= 1'b0;
            state_q    <= (start_len == '0) ? S_FIN : S_LOAD;
          end
        end
        S_LOAD: begin
          addr_q <= addr_q + AW'(1);
          k_q    <= k_q + IW'(1);
          if (LW'(k_q) == (len_q - LW'(1))) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // First DRAIN cycle only carries the final write; the skew counter starts after it.
          if (!drain_go_q) begin
            drain_go_q <= 1'b1;
          end else if (c_q == c_last) begin
            state_q <= S_FIN;
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign drain_active = (state_q == S_DRAIN) && drain_go_q;

  x_skew_gen #(
    .ROWS (ROWS),
    .LW   (LW),
    .CW   (CW)
  ) u_skew (
    .CLK       (CLK),
    .RST       (RST),
    .c         (c_q),
    .len       (len_q),
    .active    (drain_active),
    .drain_en  (drain_en),
    .row_valid (ROW_VALID)
  );

  assign BUSY     = (dbg_state != IDLE);
  assign DONE     = (dbg_state == FIN);
  assign MEM_EN   = (state_q == S_LOAD);
  assign MEM_ADDR = MEM_EN ? addr_q : '0;
  assign XR_WRITE = {ROWS{rd_vld_q}};
  assign XR_EN    = XR_WRITE | drain_en;
  assign XR_IDX   = rd_vld_q ? rd_idx_q : '0;
  assign XR_DIN   = rd_vld_q ? MEM_DATA : '0;

endmodule
